// File: rtl/peripheral_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_sequencer
// Description : Arbitrates CPU and DMA requests for the peripheral bus (PIC,
//               PIT, PPI, keyboard I/O ports and the text-VGA memory window)
//               and sequences each access as ADDR -> STROBE -> RECOVER.
//               STROBE lasts W+1 cycles (W = programmable wait states). After
//               that it is extended while bus_ready is low, up to READY_TIMEOUT
//               extension cycles. Read data is captured when STROBE ends, and a
//               one-cycle acknowledge is returned during RECOVER.
// Ports       : clock, reset            - clock, async active-high reset
//               cpu_* / dma_*           - requester interfaces (req/write/io/
//                                         address/wdata in, ack out)
//               read_data               - captured read data (shared)
//               grant_dma, bus_timeout  - DMA ownership, forced-end pulse
//               bus_address, bus_wdata  - peripheral address / write data
//               address_enable_n        - low during CPU-owned transactions
//               io_read_n, io_write_n,
//               memory_read_n,
//               memory_write_n          - active-low registered strobes
//               bus_rdata, bus_rdata_valid, bus_ready - peripheral responses
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bus_sequencer #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned READY_TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic        cpu_io,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic        dma_io,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  read_data,
    output logic        grant_dma,
    output logic        bus_timeout,
    output logic [19:0] bus_address,
    output logic [7:0]  bus_wdata,
    output logic        address_enable_n,
    output logic        io_read_n,
    output logic        io_write_n,
    output logic        memory_read_n,
    output logic        memory_write_n,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_valid,
    input  logic        bus_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT_STATES);
    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT_STATES);
    localparam logic [7:0] TIMEOUT_C  = 8'(READY_TIMEOUT);

    state_t      state_q, state_d;
    logic        owner_dma_q, owner_dma_d;
    logic        write_q, write_d;
    logic        io_q, io_d;
    logic        last_dma_q, last_dma_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  read_data_q, read_data_d;
    logic [19:0] bus_address_q, bus_address_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        aen_n_q, aen_n_d;
    logic        io_read_n_q, io_read_n_d;
    logic        io_write_n_q, io_write_n_d;
    logic        mem_read_n_q, mem_read_n_d;
    logic        mem_write_n_q, mem_write_n_d;
    logic        grant_dma_q, grant_dma_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic        timeout_q, timeout_d;

    // DMA wins when it is the only requester, or on a tie when CPU was served last.
    logic pick_dma;
    assign pick_dma = dma_req && (!cpu_req || !last_dma_q);

    always_comb begin
        state_d       = state_q;
        owner_dma_d   = owner_dma_q;
        write_d       = write_q;
        io_d          = io_q;
        last_dma_d    = last_dma_q;
        wait_cnt_d    = wait_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        read_data_d   = read_data_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        aen_n_d       = aen_n_q;
        io_read_n_d   = io_read_n_q;
        io_write_n_d  = io_write_n_q;
        mem_read_n_d  = mem_read_n_q;
        mem_write_n_d = mem_write_n_q;
        grant_dma_d   = grant_dma_q;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    // The output registers double as the latched transaction
                    // fields; they are only reloaded here.
                    owner_dma_d   = pick_dma;
                    last_dma_d    = pick_dma;
                    write_d       = pick_dma ? dma_write   : cpu_write;
                    io_d          = pick_dma ? dma_io      : cpu_io;
                    bus_address_d = pick_dma ? dma_address : cpu_address;
                    bus_wdata_d   = pick_dma ? dma_wdata   : cpu_wdata;
                    aen_n_d       = pick_dma;
                    grant_dma_d   = pick_dma;
                    state_d       = ST_ADDR;
                end
            end

            ST_ADDR: begin
                wait_cnt_d    = io_q ? IO_WAIT_C : MEM_WAIT_C;
                tmo_cnt_d     = 8'd0;
                io_read_n_d   = !( io_q && !write_q);
                io_write_n_d  = !( io_q &&  write_q);
                mem_read_n_d  = !(!io_q && !write_q);
                mem_write_n_d = !(!io_q &&  write_q);
                state_d       = ST_STROBE;
            end

            ST_STROBE: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (bus_ready || (tmo_cnt_q == TIMEOUT_C)) begin
                    // Normal completion, or forced once the extension budget is spent.
                    timeout_d     = !bus_ready;
                    io_read_n_d   = 1'b1;
                    io_write_n_d  = 1'b1;
                    mem_read_n_d  = 1'b1;
                    mem_write_n_d = 1'b1;
                    if (!write_q) begin
                        read_data_d = bus_rdata_valid ? bus_rdata : 8'hFF;
                    end
                    cpu_ack_d = !owner_dma_q;
                    dma_ack_d = owner_dma_q;
                    state_d   = ST_RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end

            ST_RECOVER: begin
                aen_n_d     = 1'b1;
                grant_dma_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_dma_q   <= 1'b0;
            write_q       <= 1'b0;
            io_q          <= 1'b0;
            last_dma_q    <= 1'b0;
            wait_cnt_q    <= 4'd0;
            tmo_cnt_q     <= 8'd0;
            read_data_q   <= 8'd0;
            bus_address_q <= 20'd0;
            bus_wdata_q   <= 8'd0;
            aen_n_q       <= 1'b1;
            io_read_n_q   <= 1'b1;
            io_write_n_q  <= 1'b1;
            mem_read_n_q  <= 1'b1;
            mem_write_n_q <= 1'b1;
            grant_dma_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_dma_q   <= owner_dma_d;
            write_q       <= write_d;
            io_q          <= io_d;
            last_dma_q    <= last_dma_d;
            wait_cnt_q    <= wait_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            read_data_q   <= read_data_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            aen_n_q       <= aen_n_d;
            io_read_n_q   <= io_read_n_d;
            io_write_n_q  <= io_write_n_d;
            mem_read_n_q  <= mem_read_n_d;
            mem_write_n_q <= mem_write_n_d;
            grant_dma_q   <= grant_dma_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
            timeout_q     <= timeout_d;
        end
    end

    assign cpu_ack          = cpu_ack_q;
    assign dma_ack          = dma_ack_q;
    assign read_data        = read_data_q;
    assign grant_dma        = grant_dma_q;
    assign bus_timeout      = timeout_q;
    assign bus_address      = bus_address_q;
    assign bus_wdata        = bus_wdata_q;
    assign address_enable_n = aen_n_q;
    assign io_read_n        = io_read_n_q;
    assign io_write_n       = io_write_n_q;
    assign memory_read_n    = mem_read_n_q;
    assign memory_write_n   = mem_write_n_q;

endmodule
`default_nettype wire

// File: doc/peripheral_bus_sequencer.md
Name: peripheral_bus_sequencer

Overview:
- Sequences every access to the peripheral bus (8259/8253/8255/keyboard I/O ports, text-VGA memory window) for two requesters: CPU and DMA.
- Arbitrates between them, then generates address phase, read/write strobe pulse with programmable wait states, and recovery phase.
- Captures read data and returns a one-cycle acknowledge.
- Sits between the CPU/DMA front ends and the peripheral block; drives its address_enable_n, io/memory strobes and address bus.

Parameters:
- IO_WAIT_STATES, 1, extra strobe cycles for I/O transactions (0-15).
- MEM_WAIT_STATES, 0, extra strobe cycles for memory transactions (0-15).
- READY_TIMEOUT, 255, maximum cycles the strobe is extended by ready low before forced termination (1-255).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU request level; held until cpu_ack.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_io  in  1  1 = I/O space, 0 = memory space.
- cpu_address  in  20  transaction address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_write, dma_io, dma_address[19:0], dma_wdata[7:0], dma_ack: same as the CPU set, for DMA.
- read_data  out  8  captured read data, shared by both requesters.
- grant_dma  out  1  high while a DMA transaction owns the bus.
- bus_timeout  out  1  one-cycle pulse when a transaction is force-terminated.
- bus_address  out  20  address to peripherals.
- bus_wdata  out  8  write data to peripherals.
- address_enable_n  out  1  low during CPU transactions only.
- io_read_n, io_write_n, memory_read_n, memory_write_n  out  1 each  active-low strobes.
- bus_rdata  in  8  peripheral read data.
- bus_rdata_valid  in  1  peripheral is driving bus_rdata.
- bus_ready  in  1  0 = extend the strobe (external wait).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State returns to IDLE.
  - All strobes and address_enable_n = 1.
  - cpu_ack, dma_ack, bus_timeout, grant_dma = 0.
  - read_data, bus_address, bus_wdata = 0.
  - last_grant = CPU.
- FSM states: IDLE, ADDR, STROBE, RECOVER.
- IDLE:
  - Samples cpu_req and dma_req.
  - If neither is set, stays in IDLE.
  - If exactly one is set, that requester wins.
  - If both are set, the requester not in last_grant wins. After reset DMA therefore wins the first tie.
  - Winner's address, wdata, write and io are latched into internal registers. Later changes on requester inputs are ignored until the transaction ends.
  - last_grant is updated to the winner.
  - Next state is ADDR.
- ADDR (1 cycle):
  - bus_address and bus_wdata driven from the latched values.
  - Strobes stay high.
  - address_enable_n = 0 for a CPU transaction, 1 for a DMA transaction.
  - grant_dma = 1 for a DMA transaction.
- STROBE:
  - Exactly one strobe is low, selected by io/write.
  - Wait counter loads IO_WAIT_STATES or MEM_WAIT_STATES on entry.
  - Minimum stay is W+1 cycles.
  - After the counter expires, STROBE extends while bus_ready = 0.
  - A separate timeout counter counts the extension cycles. On reaching READY_TIMEOUT the transaction terminates anyway and bus_timeout pulses for one cycle, coincident with the ack.
  - Read capture happens at the rising edge that leaves STROBE:
    - read_data <= bus_rdata if bus_rdata_valid = 1, else 8'hFF (open bus).
    - Forced termination uses the same rule.
  - Writes do not modify read_data.
- RECOVER (1 cycle):
  - Strobes high.
  - Address, address_enable_n and grant_dma hold their values.
  - The owner's ack = 1 for exactly this cycle.
  - Next state is IDLE.
- After RECOVER, bus_address and bus_wdata keep their last values; address_enable_n returns to 1 and grant_dma to 0.
- Latency: request sampled in IDLE at cycle t → ADDR t+1 → STROBE t+2 … t+2+W+E → ack at t+3+W+E. E is the ready-extension cycle count.
- Back-to-back throughput: 4+W cycles per transaction.
- Requester rule: deassert req at the edge ending the ack cycle. The sequencer never samples req during RECOVER, so no duplicate transaction occurs.
- Strobes are glitch-free registered outputs. At most one strobe is low in any cycle.
- A req that drops before its grant is never served.

Test Plan:
- CPU I/O read of 0x0021, IO_WAIT_STATES=1, bus_rdata=8'h5A, valid=1 → address_enable_n low cycles 1-4, io_read_n low cycles 2-3, cpu_ack at cycle 4, read_data=8'h5A.
- DMA memory write to 0xB8000, wdata=8'h41, MEM_WAIT_STATES=0 → grant_dma=1, address_enable_n stays 1, memory_write_n low for 1 cycle, dma_ack 3 cycles after request sample, read_data unchanged.
- CPU and DMA requesting continuously from reset → grants alternate DMA, CPU, DMA, CPU; each ack exactly once per transaction; no overlapping strobes.
- CPU memory read with bus_ready low for 5 cycles after the wait count → strobe low 5 extra cycles; ack follows the first cycle with ready = 1; bus_timeout stays 0.
- bus_ready held low, READY_TIMEOUT=4, read with bus_rdata_valid=0 → forced end after 4 extension cycles; bus_timeout and ack coincide; read_data=8'hFF.
- Reset asserted while in STROBE of an I/O write → io_write_n = 1 immediately; no ack issued; first transaction after release gets its grant with full ADDR/STROBE/RECOVER timing.
